// File: rtl/map_loader_pkg.sv
// Shared game package: cell codes, map index constants, board size defaults,
// loader FSM state encoding and the select-clamping helper.
package map_loader_pkg;

    // Board cell codes stored in the map ROM and in the board RAM.
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_WALL  = 2'd1,
        CELL_BLUE  = 2'd2,
        CELL_RED   = 2'd3
    } cell_t;

    // Map 0 is the menu screen; play maps start at 1.
    localparam logic [1:0] MAP_MENU       = 2'd0;
    localparam logic [1:0] MAP_FIRST_PLAY = 2'd1;

    localparam int GRID_W_DEFAULT = 80;
    localparam int GRID_H_DEFAULT = 60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    // Out-of-range selects fall back to the menu map.
    function automatic logic [1:0] clamp_sel(input logic [1:0] sel, input int num_maps);
        return (int'(sel) >= num_maps) ? MAP_MENU : sel;
    endfunction

    function automatic logic sel_out_of_range(input logic [1:0] sel, input int num_maps);
        return int'(sel) >= num_maps;
    endfunction

endpackage

// File: rtl/map_loader_delay.sv
// ROM read-latency matcher: a LATENCY-deep shift register carrying a valid
// bit and the cell index of every issued ROM read, so the index arrives at the
// RAM write port together with the matching rom_data.
// Ports:
//   Clk, Reset_n      clock, asynchronous active-low clear
//   in_valid, in_idx  read issued this cycle and its cell index
//   out_valid, out_idx  read whose data is on rom_data this cycle
//   inflight          a valid sits in any stage other than the last one,
//                     i.e. the line is not empty after the next edge
module map_loader_delay #(
    parameter int LATENCY = 1,
    parameter int IDX_W   = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             inflight
);

    logic [LATENCY-1:0] v;
    logic [IDX_W-1:0]   ix [LATENCY];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                ix[i] <= '0;
            end
        end else begin
            v[0]  <= in_valid;
            ix[0] <= in_idx;
            for (int i = 1; i < LATENCY; i++) begin
                v[i]  <= v[i-1];
                ix[i] <= ix[i-1];
            end
        end
    end

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            inflight = inflight | v[i];
        end
    end

    assign out_valid = v[LATENCY-1];
    assign out_idx   = ix[LATENCY-1];

endmodule

// File: rtl/map_loader.sv
// Map loader: copies one map (GRID_W*GRID_H cells) from the shared map ROM
// into the board RAM on request from the game FSM.
// Ports:
//   Clk, Reset_n         clock, asynchronous active-low reset
//   load_background      load request level (acted on while high)
//   background_select    map index to load (clamped to the menu if out of range)
//   rom_addr / rom_data  map ROM read port, data ROM_LATENCY cycles after address
//   ram_we/ram_addr/ram_wdata  board RAM write port
//   busy                 copy in progress (first issue through last write)
//   load_done            one-cycle pulse when a copy completes
//   loaded_map           last fully loaded map index
//   sel_error            sticky flag, an out-of-range select was clamped
//   fsm_state            current loader state (debug visibility)
//
// Handshake: load_background is a level request. In IDLE a high level starts a
// copy. While a copy runs, a new request (a high level not continuing the one
// that started the copy) is remembered in pending/pending_sel, newest select
// wins, and starts the next copy straight out of DONE. A level that is high
// during DONE itself starts a reload immediately.
module map_loader
    import map_loader_pkg::*;
#(
    parameter int GRID_W      = GRID_W_DEFAULT,
    parameter int GRID_H      = GRID_H_DEFAULT,
    parameter int NUM_MAPS    = 4,
    parameter int ROM_LATENCY = 1,
    parameter int CELL_W      = 2,
    localparam int N          = GRID_W * GRID_H,
    localparam int IDX_W      = $clog2(N),
    localparam int ROM_AW     = $clog2(NUM_MAPS * N)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load_background,
    input  logic [1:0]        background_select,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [CELL_W-1:0] rom_data,
    output logic              ram_we,
    output logic [IDX_W-1:0]  ram_addr,
    output logic [CELL_W-1:0] ram_wdata,
    output logic              busy,
    output logic              load_done,
    output logic [1:0]        loaded_map,
    output logic              sel_error,
    output logic [1:0]        fsm_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    load_state_t      state, state_d;
    logic [IDX_W-1:0] idx;
    logic [1:0]       cur_map;
    logic [1:0]       loaded_q;
    logic             pending;
    logic [1:0]       pending_sel;
    logic             held;

    logic             start;
    logic [1:0]       start_sel;
    logic             set_pending;
    logic             clear_pending;
    logic             take_req_error;

    logic             d_valid;
    logic [IDX_W-1:0] d_idx;
    logic             d_inflight;

    // Next-state and control decode.
    always_comb begin
        state_d        = state;
        start          = 1'b0;
        start_sel      = cur_map;
        set_pending    = 1'b0;
        clear_pending  = 1'b0;
        take_req_error = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_background) begin
                    start          = 1'b1;
                    start_sel      = clamp_sel(background_select, NUM_MAPS);
                    take_req_error = sel_out_of_range(background_select, NUM_MAPS);
                    state_d        = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (idx == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
                // A level still held from the accepted request is not a new one.
                if (load_background && !held) begin
                    set_pending    = 1'b1;
                    take_req_error = sel_out_of_range(background_select, NUM_MAPS);
                end
            end
            ST_DRAIN: begin
                if (!d_inflight) begin
                    state_d = ST_DONE;
                end
                if (load_background && !held) begin
                    set_pending    = 1'b1;
                    take_req_error = sel_out_of_range(background_select, NUM_MAPS);
                end
            end
            ST_DONE: begin
                clear_pending = 1'b1;
                state_d       = ST_IDLE;
                if (load_background) begin
                    start          = 1'b1;
                    start_sel      = clamp_sel(background_select, NUM_MAPS);
                    take_req_error = sel_out_of_range(background_select, NUM_MAPS);
                    state_d        = ST_FETCH;
                end else if (pending) begin
                    start     = 1'b1;
                    start_sel = pending_sel;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx         <= '0;
            cur_map     <= MAP_MENU;
            loaded_q    <= MAP_MENU;
            pending     <= 1'b0;
            pending_sel <= MAP_MENU;
            held        <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            if (start) begin
                cur_map <= start_sel;
                idx     <= '0;
            end else if (state == ST_FETCH && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end

            if (clear_pending) begin
                pending <= 1'b0;
            end else if (set_pending) begin
                pending     <= 1'b1;
                pending_sel <= clamp_sel(background_select, NUM_MAPS);
            end

            // Tracks the request level that started the running copy.
            held <= load_background && (held || start);

            if (state == ST_DONE) begin
                loaded_q <= cur_map;
            end

            if (take_req_error) begin
                sel_error <= 1'b1;
            end
        end
    end

    map_loader_delay #(
        .LATENCY (ROM_LATENCY),
        .IDX_W   (IDX_W)
    ) u_delay (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (state == ST_FETCH),
        .in_idx    (idx),
        .out_valid (d_valid),
        .out_idx   (d_idx),
        .inflight  (d_inflight)
    );

    // Full-width base + offset, so a map never wraps into its neighbour.
    always_comb begin
        rom_addr = '0;
        if (state == ST_FETCH) begin
            rom_addr = ROM_AW'(cur_map) * ROM_AW'(N) + ROM_AW'(idx);
        end
    end

    assign ram_we     = d_valid;
    assign ram_addr   = d_valid ? d_idx : '0;
    assign ram_wdata  = d_valid ? rom_data : '0;
    assign busy       = (state == ST_FETCH) || (state == ST_DRAIN);
    assign load_done  = (state == ST_DONE);
    assign loaded_map = (state == ST_DONE) ? cur_map : loaded_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader with a 4x2 board (N=8).
// Instance a: ROM_LATENCY=1, NUM_MAPS=4. Instance b: ROM_LATENCY=3, NUM_MAPS=4.
// Instance c: ROM_LATENCY=1, NUM_MAPS=3. ROM model: map m cell i = (m+i)%4.
module tb_map_loader;

    logic Clk;
    logic Reset_n;
    int   cyc;

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic       lb_a, lb_b, lb_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic [4:0] rom_addr_a, rom_addr_b, rom_addr_c;
    logic [1:0] rom_data_a, rom_data_b, rom_data_c;
    logic       we_a, we_b, we_c;
    logic [2:0] waddr_a, waddr_b, waddr_c;
    logic [1:0] wdata_a, wdata_b, wdata_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [1:0] lmap_a, lmap_b, lmap_c;
    logic       serr_a, serr_b, serr_c;
    logic [1:0] st_a, st_b, st_c;

    map_loader #(.GRID_W(4), .GRID_H(2), .NUM_MAPS(4), .ROM_LATENCY(1), .CELL_W(2)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .load_background(lb_a), .background_select(sel_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .ram_we(we_a), .ram_addr(waddr_a),
        .ram_wdata(wdata_a), .busy(busy_a), .load_done(done_a), .loaded_map(lmap_a),
        .sel_error(serr_a), .fsm_state(st_a));

    map_loader #(.GRID_W(4), .GRID_H(2), .NUM_MAPS(4), .ROM_LATENCY(3), .CELL_W(2)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .load_background(lb_b), .background_select(sel_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .ram_we(we_b), .ram_addr(waddr_b),
        .ram_wdata(wdata_b), .busy(busy_b), .load_done(done_b), .loaded_map(lmap_b),
        .sel_error(serr_b), .fsm_state(st_b));

    map_loader #(.GRID_W(4), .GRID_H(2), .NUM_MAPS(3), .ROM_LATENCY(1), .CELL_W(2)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .load_background(lb_c), .background_select(sel_c),
        .rom_addr(rom_addr_c), .rom_data(rom_data_c), .ram_we(we_c), .ram_addr(waddr_c),
        .ram_wdata(wdata_c), .busy(busy_c), .load_done(done_c), .loaded_map(lmap_c),
        .sel_error(serr_c), .fsm_state(st_c));

    // ---------------- ROM models ----------------
    function automatic logic [1:0] rom_f(input logic [4:0] a);
        int ai;
        ai = int'(a);
        return 2'((ai / 8 + ai % 8) % 4);
    endfunction

    logic [1:0] rom_b_p1, rom_b_p2;
    always @(posedge Clk) begin
        rom_data_a <= rom_f(rom_addr_a);
        rom_data_c <= rom_f(rom_addr_c);
        rom_b_p1   <= rom_f(rom_addr_b);
        rom_b_p2   <= rom_b_p1;
        rom_data_b <= rom_b_p2;
    end

    // ---------------- scoreboard ----------------
    // Entry: [31:16] cycle (raw in obs_q, relative to t0 in exp_q), [15:2] addr, [1:0] data.
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          done_q[$];
    int          mon_sel;
    int          tests_run;
    int          tests_failed;

    always @(negedge Clk) begin
        if (Reset_n) begin
            case (mon_sel)
                0: begin
                    if (we_a) obs_q.push_back({cyc[15:0], 11'd0, waddr_a, wdata_a});
                    if (done_a) done_q.push_back(cyc);
                end
                1: begin
                    if (we_b) obs_q.push_back({cyc[15:0], 11'd0, waddr_b, wdata_b});
                    if (done_b) done_q.push_back(cyc);
                end
                default: begin
                    if (we_c) obs_q.push_back({cyc[15:0], 11'd0, waddr_c, wdata_c});
                    if (done_c) done_q.push_back(cyc);
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected 8 writes of map m, first one in relative cycle first_rel.
    task automatic exp_load(input int first_rel, input int m);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({16'(first_rel + i), 14'(i), 2'((m + i) % 4)});
        end
    endtask

    task automatic check_writes(input string tag, input int t0c);
        logic [31:0] o, e;
        int n;
        check({tag, " nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, " wcyc"}, 32'(int'(o[31:16]) - t0c + 1), 32'(e[31:16]));
            check({tag, " waddr"}, 32'(o[15:2]), 32'(e[15:2]));
            check({tag, " wdata"}, 32'(o[1:0]), 32'(e[1:0]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_done(input string tag, input int t0c, input int exp_rel);
        int d;
        if (done_q.size() == 0) begin
            check({tag, " done present"}, 0, 1);
        end else begin
            d = done_q.pop_front();
            check({tag, " done cyc"}, 32'(d - t0c + 1), 32'(exp_rel));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_req(input int inst, input logic v, input logic [1:0] s);
        case (inst)
            0: begin lb_a = v; sel_a = s; end
            1: begin lb_b = v; sel_b = s; end
            default: begin lb_c = v; sel_c = s; end
        endcase
    endtask

    // One-cycle request; t0c is the cycle stamp seen in cycle t0+1.
    task automatic pulse_req(input int inst, input logic [1:0] s, output int t0c);
        @(negedge Clk);
        set_req(inst, 1'b1, s);
        @(posedge Clk);
        #1;
        t0c = cyc;
        set_req(inst, 1'b0, 2'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t0c;
        cyc = 0;
        tests_run = 0;
        tests_failed = 0;
        mon_sel = 0;
        Reset_n = 1'b0;
        lb_a = 0; lb_b = 0; lb_c = 0;
        sel_a = 0; sel_b = 0; sel_c = 0;
        wait_cycles(3);

        // Reset state
        check("rst busy", busy_a, 0);
        check("rst we", we_a, 0);
        check("rst done", done_a, 0);
        check("rst lmap", lmap_a, 0);
        check("rst serr", serr_a, 0);
        check("rst rom_addr", rom_addr_a, 0);
        check("rst state", st_a, 0);
        check("rst b we", we_b, 0);
        Reset_n = 1'b1;
        wait_cycles(2);

        // T1: latency 1, map 1
        mon_sel = 0;
        pulse_req(0, 2'd1, t0c);
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            check("t1 rom_addr", rom_addr_a, (k <= 8) ? 32'(8 + k - 1) : 32'd0);
            check("t1 busy", busy_a, (k <= 9) ? 1 : 0);
            check("t1 done", done_a, (k == 10) ? 1 : 0);
            if (k == 10) check("t1 lmap", lmap_a, 1);
        end
        wait_cycles(2);
        exp_load(2, 1);
        check_writes("t1", t0c);
        check_done("t1", t0c, 10);
        check("t1 ndone", done_q.size(), 0);
        check("t1 lmap hold", lmap_a, 1);

        // T2: latency 3, map 2
        mon_sel = 1;
        done_q.delete();
        pulse_req(1, 2'd2, t0c);
        wait_cycles(15);
        exp_load(4, 2);
        check_writes("t2", t0c);
        check_done("t2", t0c, 12);
        check("t2 lmap", lmap_b, 2);
        check("t2 busy", busy_b, 0);

        // T3: requests while busy, newest pending wins
        mon_sel = 0;
        done_q.delete();
        pulse_req(0, 2'd1, t0c);
        @(posedge Clk); @(posedge Clk);     // edges t0+1, t0+2
        #1 set_req(0, 1'b1, 2'd3);
        @(posedge Clk);                      // edge t0+3
        #1 set_req(0, 1'b0, 2'd0);
        @(posedge Clk);                      // edge t0+4
        #1 set_req(0, 1'b1, 2'd2);
        @(posedge Clk);                      // edge t0+5
        #1 set_req(0, 1'b0, 2'd0);
        wait_cycles(22);
        exp_load(2, 1);
        exp_load(12, 2);
        check_writes("t3", t0c);
        check("t3 ndone", done_q.size(), 2);
        check_done("t3 first", t0c, 10);
        check_done("t3 second", t0c, 20);
        check("t3 lmap", lmap_a, 2);

        // T4: NUM_MAPS=3, select 3 clamps to menu
        mon_sel = 2;
        done_q.delete();
        check("t4 serr before", serr_c, 0);
        pulse_req(2, 2'd3, t0c);
        wait_cycles(12);
        exp_load(2, 0);
        check_writes("t4", t0c);
        check_done("t4", t0c, 10);
        check("t4 lmap", lmap_c, 0);
        check("t4 serr", serr_c, 1);
        pulse_req(2, 2'd1, t0c);
        wait_cycles(12);
        check("t4 lmap2", lmap_c, 1);
        check("t4 serr sticky", serr_c, 1);
        obs_q.delete();
        done_q.delete();

        // T5: reset in the middle of a copy
        mon_sel = 0;
        pulse_req(0, 2'd1, t0c);
        @(posedge Clk); @(posedge Clk); @(posedge Clk);   // edges t0+1..t0+3
        #2;
        check("t5 we before", we_a, 1);
        Reset_n = 1'b0;
        #1;
        check("t5 we async", we_a, 0);
        check("t5 busy async", busy_a, 0);
        check("t5 done async", done_a, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        obs_q.delete();
        done_q.delete();
        wait_cycles(12);
        check("t5 no writes", obs_q.size(), 0);
        check("t5 no done", done_q.size(), 0);
        check("t5 busy idle", busy_a, 0);

        // T6: request held three cycles starts one load
        @(negedge Clk);
        set_req(0, 1'b1, 2'd2);
        @(posedge Clk);
        #1 t0c = cyc;
        @(posedge Clk); @(posedge Clk);
        #1 set_req(0, 1'b0, 2'd0);
        wait_cycles(25);
        exp_load(2, 2);
        check_writes("t6", t0c);
        check("t6 ndone", done_q.size(), 1);
        check_done("t6", t0c, 10);
        check("t6 lmap", lmap_a, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
